// File: rtl/demux_12_stream.sv
// Streaming 1-to-2 demultiplexer with a 2-entry buffer on each output.
// Optional per-output accepted-beat counters are enabled by DEMUX_12_STATS_EN.

module demux_12_fifo2 #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic             full_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] data_o
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic                   wr_ptr_q, wr_ptr_d;
   logic                   rd_ptr_q, rd_ptr_d;
   logic [1:0][WIDTH-1:0]  mem_q;
   logic [WIDTH-1:0]       hold_q;
   logic                   pop;

   assign pop     = pop_i & valid_o;
   assign valid_o = (state_q != ST_EMPTY);
   assign full_o  = (state_q == ST_FULL);
   // Head of the buffer; while empty, keep showing the last value presented.
   assign data_o  = valid_o ? mem_q[rd_ptr_q] : hold_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_EMPTY;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         mem_q    <= '0;
         hold_q   <= '0;
      end else begin
         state_q  <= state_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         hold_q   <= data_o;
         if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_i) begin
         wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case (state_q)
         ST_EMPTY: begin
            if (push_i) state_d = ST_ONE;
         end
         ST_ONE: begin
            if (push_i && !pop)      state_d = ST_FULL;
            else if (pop && !push_i) state_d = ST_EMPTY;
         end
         ST_FULL: begin
            if (pop && !push_i) state_d = ST_ONE;
         end
         default: state_d = ST_EMPTY;
      endcase
   end

endmodule

module demux_12_stream #(
   parameter int unsigned WIDTH = 8
`ifdef DEMUX_12_STATS_EN
   ,
   parameter int unsigned CNT_W = 16
`endif
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sel,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_a_valid,
   output logic [WIDTH-1:0] out_a_data,
   input  logic             out_a_ready,
   output logic             out_b_valid,
   output logic [WIDTH-1:0] out_b_data,
   input  logic             out_b_ready
`ifdef DEMUX_12_STATS_EN
   ,
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b
`endif
);

   logic full_a, full_b;
   logic accept, push_a, push_b;

   // Ready depends only on the selected buffer's fill state, never on the pop.
   assign in_ready = !rst && (sel ? !full_b : !full_a);
   assign accept   = in_valid && in_ready;
   assign push_a   = accept && !sel;
   assign push_b   = accept && sel;

   demux_12_fifo2 #(.WIDTH(WIDTH)) u_buf_a (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_a),
      .data_i  (in_data),
      .pop_i   (out_a_ready),
      .full_o  (full_a),
      .valid_o (out_a_valid),
      .data_o  (out_a_data)
   );

   demux_12_fifo2 #(.WIDTH(WIDTH)) u_buf_b (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push_b),
      .data_i  (in_data),
      .pop_i   (out_b_ready),
      .full_o  (full_b),
      .valid_o (out_b_valid),
      .data_o  (out_b_data)
   );

`ifdef DEMUX_12_STATS_EN
   logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
   logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

   always_comb begin
      cnt_a_d = cnt_a_q;
      cnt_b_d = cnt_b_q;
      if (push_a) cnt_a_d = cnt_a_q + CNT_W'(1);
      if (push_b) cnt_b_d = cnt_b_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_a_q <= '0;
         cnt_b_q <= '0;
      end else begin
         cnt_a_q <= cnt_a_d;
         cnt_b_q <= cnt_b_d;
      end
   end

   assign cnt_a = cnt_a_q;
   assign cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_demux_12_stream.sv
// Self-checking bench for demux_12_stream: directed vector table plus
// reset, scoreboard, pointer-wrap and (with DEMUX_12_STATS_EN) counter sequences.

module tb_demux_12_stream;

   localparam int unsigned WIDTH = 8;
`ifdef DEMUX_12_STATS_EN
   localparam int unsigned CNT_W = 4;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             sel;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_a_valid;
   logic [WIDTH-1:0] out_a_data;
   logic             out_a_ready;
   logic             out_b_valid;
   logic [WIDTH-1:0] out_b_data;
   logic             out_b_ready;
`ifdef DEMUX_12_STATS_EN
   logic [CNT_W-1:0] cnt_a;
   logic [CNT_W-1:0] cnt_b;
`endif

   int n_cmp = 0;
   int n_err = 0;

   demux_12_stream #(
      .WIDTH(WIDTH)
`ifdef DEMUX_12_STATS_EN
      , .CNT_W(CNT_W)
`endif
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sel         (sel),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .out_a_valid (out_a_valid),
      .out_a_data  (out_a_data),
      .out_a_ready (out_a_ready),
      .out_b_valid (out_b_valid),
      .out_b_data  (out_b_data),
      .out_b_ready (out_b_ready)
`ifdef DEMUX_12_STATS_EN
      , .cnt_a     (cnt_a),
      .cnt_b       (cnt_b)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       sel;
      logic       vld;
      logic [7:0] data;
      logic       ar;
      logic       br;
      logic       e_rdy;
      logic       e_av;
      logic [7:0] e_ad;
      logic       e_bv;
      logic [7:0] e_bd;
   } vec_t;

   vec_t vecs[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic s, input logic v, input logic [7:0] d,
                        input logic ar, input logic br);
      sel = s; in_valid = v; in_data = d; out_a_ready = ar; out_b_ready = br;
   endtask

   logic [7:0] qa[$];
   logic [7:0] qb[$];

   initial begin
      int sent, rcvd;
      logic m_rdy;
      logic rs, rv, rar, rbr;
      logic [7:0] rd;

      // sel vld data ar br | rdy av ad bv bd  (sampled before the edge)
      vecs[0]  = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00};
      vecs[1]  = '{1'b1, 1'b1, 8'h22, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b0, 8'h00};
      vecs[2]  = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 1'b0, 8'h11, 1'b1, 8'h22};
      vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33, 1'b0, 8'h22};
      vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h33, 1'b0, 8'h22};
      vecs[5]  = '{1'b0, 1'b1, 8'hA0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h33, 1'b0, 8'h22};
      vecs[6]  = '{1'b0, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA0, 1'b0, 8'h22};
      vecs[7]  = '{1'b0, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA0, 1'b0, 8'h22};
      vecs[8]  = '{1'b1, 1'b1, 8'hB0, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA0, 1'b0, 8'h22};
      vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA0, 1'b1, 8'hB0};
      vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA0, 1'b1, 8'hB0};
      vecs[11] = '{1'b0, 1'b1, 8'h05, 1'b1, 1'b1, 1'b1, 1'b1, 8'hA1, 1'b0, 8'hB0};
      vecs[12] = '{1'b0, 1'b1, 8'h06, 1'b1, 1'b1, 1'b1, 1'b1, 8'h05, 1'b0, 8'hB0};
      vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h06, 1'b0, 8'hB0};
      vecs[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 8'h06, 1'b0, 8'hB0};
      vecs[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h06, 1'b0, 8'hB0};

      rst = 1'b1;
      drive(1'b0, 1'b1, 8'h5A, 1'b1, 1'b1);
      @(negedge clk); #1;
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_a_valid",  32'(out_a_valid), 32'd0);
      chk("rst_b_valid",  32'(out_b_valid), 32'd0);
      chk("rst_a_data",   32'(out_a_data), 32'd0);
      chk("rst_b_data",   32'(out_b_data), 32'd0);
      rst = 1'b0;
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);

      // Routing, full/stall, simultaneous push/pop
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         drive(vecs[i].sel, vecs[i].vld, vecs[i].data, vecs[i].ar, vecs[i].br);
         #1;
         chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
         chk($sformatf("v%0d_a_valid", i), 32'(out_a_valid), 32'(vecs[i].e_av));
         chk($sformatf("v%0d_a_data", i), 32'(out_a_data), 32'(vecs[i].e_ad));
         chk($sformatf("v%0d_b_valid", i), 32'(out_b_valid), 32'(vecs[i].e_bv));
         chk($sformatf("v%0d_b_data", i), 32'(out_b_data), 32'(vecs[i].e_bd));
      end

      // Reset mid-stream with A holding two beats
      @(negedge clk); drive(1'b0, 1'b1, 8'hC1, 1'b0, 1'b1);
      @(negedge clk); drive(1'b0, 1'b1, 8'hC2, 1'b0, 1'b1);
      @(negedge clk); drive(1'b0, 1'b1, 8'hC3, 1'b0, 1'b1);
      #1;
      chk("mid_full_a", 32'(in_ready), 32'd0);
      chk("mid_a_valid", 32'(out_a_valid), 32'd1);
      rst = 1'b1;
      #1;
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      chk("mid_rst_a_valid", 32'(out_a_valid), 32'd0);
      chk("mid_rst_b_valid", 32'(out_b_valid), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      #1;
      chk("rel_in_ready", 32'(in_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         chk($sformatf("rel_a_valid%0d", i), 32'(out_a_valid), 32'd0);
         chk($sformatf("rel_b_valid%0d", i), 32'(out_b_valid), 32'd0);
      end

      // Random traffic against a queue scoreboard, then drain
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         rs  = 1'($urandom_range(0, 1));
         rv  = (c < 20) ? 1'($urandom_range(0, 1)) : 1'b0;
         rd  = 8'($urandom_range(0, 255));
         rar = (c < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
         rbr = (c < 20) ? 1'($urandom_range(0, 1)) : 1'b1;
         drive(rs, rv, rd, rar, rbr);
         #1;
         m_rdy = rs ? (qb.size() < 2) : (qa.size() < 2);
         chk($sformatf("rnd%0d_in_ready", c), 32'(in_ready), 32'(m_rdy));
         chk($sformatf("rnd%0d_a_valid", c), 32'(out_a_valid), 32'(qa.size() != 0));
         chk($sformatf("rnd%0d_b_valid", c), 32'(out_b_valid), 32'(qb.size() != 0));
         if (qa.size() != 0) chk($sformatf("rnd%0d_a_data", c), 32'(out_a_data), 32'(qa[0]));
         if (qb.size() != 0) chk($sformatf("rnd%0d_b_data", c), 32'(out_b_data), 32'(qb[0]));
         if (qa.size() != 0 && rar) void'(qa.pop_front());
         if (qb.size() != 0 && rbr) void'(qb.pop_front());
         if (rv && m_rdy) begin
            if (rs) qb.push_back(rd);
            else    qa.push_back(rd);
         end
      end
      @(negedge clk); #1;
      chk("drain_a_empty", 32'(out_a_valid), 32'd0);
      chk("drain_b_empty", 32'(out_b_valid), 32'd0);

      // Six beats through B with random consumer stalls; pointers wrap
      sent = 0;
      rcvd = 0;
      for (int c = 0; c < 200 && rcvd < 6; c++) begin
         @(negedge clk);
         drive(1'b1, (sent < 6), 8'(sent + 1), 1'b1, 1'($urandom_range(0, 1)));
         #1;
         if (out_b_valid && out_b_ready) begin
            chk($sformatf("wrap_beat%0d", rcvd), 32'(out_b_data), 32'(rcvd + 1));
            rcvd++;
         end
         if (in_valid && in_ready) sent++;
      end
      chk("wrap_count", 32'(rcvd), 32'd6);

`ifdef DEMUX_12_STATS_EN
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      #1;
      chk("cnt_a_rst", 32'(cnt_a), 32'd0);
      chk("cnt_b_rst", 32'(cnt_b), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         drive((i >= 17), 1'b1, 8'(i), 1'b1, 1'b1);
      end
      @(negedge clk);
      drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
      #1;
      chk("cnt_a_wrap", 32'(cnt_a), 32'd1);
      chk("cnt_b", 32'(cnt_b), 32'd3);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
